systolic_layer_scheduler: RTL and testbench

Sequences the systolic data buffer one layer at a time. Accepts layer descriptors over a valid/ready port into a small FIFO, validates them, and requests weight and ifmap loads from the unified-buffer loaders. It then issues the one-cycle `layer_info_valid`/`send_sd_en` start to the data buffer, tracks `sd_ov` to completion, waits for the array to drain and reports `layer_done`. Sits between the top-level host/command path and the systolic data buffer plus array.

---
 rtl/systolic_layer_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_systolic_layer_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_layer_scheduler.sv
// Purpose: per-layer sequencer for the systolic data buffer: descriptor FIFO, validation, weight/ifmap loads, start, drain, done.
// Latency: pop to start pulse >= 3 cycles; layer_done comes DRAIN_CYCLES+1 cycles after sd_ov is first seen low.
// Backpressure: desc_ready is low while the FIFO holds DESC_DEPTH entries (registered count, no same-cycle pop credit).
// Optional feature macro SCHED_PERF_CNT_EN: busy-cycle and layer counters; without it both perf outputs are tied to 0.
module systolic_layer_scheduler #(
   parameter int HEIGHT        = 8,
   parameter int WIDTH         = 8,
   parameter int DESC_DEPTH    = 4,
   parameter int DRAIN_CYCLES  = HEIGHT + WIDTH,
   parameter int START_TIMEOUT = 4,
   parameter int HEIGHT_W      = $clog2(HEIGHT),
   parameter int WIDTH_W       = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                desc_valid,
   output logic                desc_ready,
   input  logic [HEIGHT_W:0]   desc_ifmap_height,
   input  logic [HEIGHT_W:0]   desc_ifmap_width,
   input  logic [HEIGHT_W:0]   desc_weight_height,
   input  logic                desc_op,
   output logic                wload_req,
   input  logic                wload_done,
   output logic                ifload_req,
   input  logic                ifload_done,
   output logic                layer_info_valid,
   output logic                send_sd_en,
   output logic [HEIGHT_W:0]   ifmap_height_o,
   output logic [HEIGHT_W:0]   ifmap_width_o,
   output logic [HEIGHT_W:0]   weight_height_o,
   output logic                op_o,
   input  logic                sd_ov,
   output logic                layer_done,
   output logic                busy,
   output logic                err_desc,
   output logic                err_timeout,
   input  logic                err_clr,
   output logic [31:0]         perf_busy_cycles,
   output logic [15:0]         perf_layers
);
   localparam int PTR_W = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int DC_W  = $clog2(DRAIN_CYCLES + 1);
   localparam int TO_W  = $clog2(START_TIMEOUT + 1);
   localparam int CMP_W = ((HEIGHT_W > WIDTH_W) ? HEIGHT_W : WIDTH_W) + 2;

   typedef struct packed {
      logic              op;
      logic [HEIGHT_W:0] wh;
      logic [HEIGHT_W:0] w;
      logic [HEIGHT_W:0] h;
   } desc_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_IF, S_START, S_RUN, S_DRAIN, S_DONE
   } state_t;

   // Dimensions are widened before comparing so the limits fit regardless of field width.
   function automatic logic desc_legal(input desc_t d);
      logic [CMP_W-1:0] h, w, wh;
      h  = CMP_W'(d.h);
      w  = CMP_W'(d.w);
      wh = CMP_W'(d.wh);
      return (h != '0) && (h <= CMP_W'(HEIGHT)) &&
             (w != '0) && (w <= CMP_W'(WIDTH)) &&
             (wh != '0) && (wh <= CMP_W'(HEIGHT)) &&
             (d.op || (wh <= h));
   endfunction

   state_t            state_q, state_d;
   desc_t             mem_q [DESC_DEPTH];
   desc_t             mem_d [DESC_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   desc_t             cur_q, cur_d;
   logic [DC_W-1:0]   dcnt_q, dcnt_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              seen_q, seen_d;
   logic              desc_ready_q, desc_ready_d;
   logic              busy_q, busy_d;
   logic              wload_req_q, wload_req_d;
   logic              ifload_req_q, ifload_req_d;
   logic              start_q, start_d;
   logic              layer_done_q, layer_done_d;
   logic              err_desc_q, err_desc_d;
   logic              err_timeout_q, err_timeout_d;
   logic              push, pop, set_err_desc, set_err_to;
   desc_t             head, in_desc;

   assign in_desc = {desc_op, desc_weight_height, desc_ifmap_width, desc_ifmap_height};

   // Next-state, FIFO bookkeeping and next values of every registered output.
   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cur_d        = cur_q;
      dcnt_d       = dcnt_q;
      tcnt_d       = tcnt_q;
      seen_d       = seen_q;
      push         = desc_valid && desc_ready_q;
      pop          = 1'b0;
      set_err_desc = 1'b0;
      set_err_to   = 1'b0;
      head         = mem_q[rd_ptr_q];
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
               if (desc_legal(head)) begin
                  cur_d   = head;
                  state_d = S_LOAD_W;
               end else begin
                  set_err_desc = 1'b1;
               end
            end
         end
         S_LOAD_W:  if (wload_done)  state_d = S_LOAD_IF;
         S_LOAD_IF: if (ifload_done) state_d = S_START;
         S_START: begin
            tcnt_d  = '0;
            seen_d  = 1'b0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (sd_ov) begin
               seen_d = 1'b1;
            end else if (seen_q) begin
               dcnt_d  = '0;
               state_d = S_DRAIN;
            end else if (tcnt_q == TO_W'(START_TIMEOUT - 2)) begin
               // Last cycle of the window: the error shows START_TIMEOUT cycles after the start pulse.
               set_err_to = 1'b1;
               state_d    = S_IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (dcnt_q == DC_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
            else                                   dcnt_d  = dcnt_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = in_desc;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // A same-cycle set beats the clear.
      err_desc_d    = set_err_desc | (err_desc_q & ~err_clr);
      err_timeout_d = set_err_to | (err_timeout_q & ~err_clr);

      desc_ready_d  = (count_d != CNT_W'(DESC_DEPTH));
      busy_d        = (state_d != S_IDLE) || (count_d != '0);
      wload_req_d   = (state_d == S_LOAD_W);
      ifload_req_d  = (state_d == S_LOAD_IF);
      start_d       = (state_d == S_START);
      layer_done_d  = (state_d == S_DONE);
   end

   // Control state and registered outputs; reset flushes the FIFO and aborts any layer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         cur_q         <= '0;
         dcnt_q        <= '0;
         tcnt_q        <= '0;
         seen_q        <= 1'b0;
         desc_ready_q  <= 1'b1;
         busy_q        <= 1'b0;
         wload_req_q   <= 1'b0;
         ifload_req_q  <= 1'b0;
         start_q       <= 1'b0;
         layer_done_q  <= 1'b0;
         err_desc_q    <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         cur_q         <= cur_d;
         dcnt_q        <= dcnt_d;
         tcnt_q        <= tcnt_d;
         seen_q        <= seen_d;
         desc_ready_q  <= desc_ready_d;
         busy_q        <= busy_d;
         wload_req_q   <= wload_req_d;
         ifload_req_q  <= ifload_req_d;
         start_q       <= start_d;
         layer_done_q  <= layer_done_d;
         err_desc_q    <= err_desc_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   // Descriptor storage; contents are only meaningful under the valid count, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign desc_ready       = desc_ready_q;
   assign busy             = busy_q;
   assign wload_req        = wload_req_q;
   assign ifload_req       = ifload_req_q;
   assign layer_info_valid = start_q;
   assign send_sd_en       = start_q;
   assign layer_done       = layer_done_q;
   assign err_desc         = err_desc_q;
   assign err_timeout      = err_timeout_q;
   assign ifmap_height_o   = cur_q.h;
   assign ifmap_width_o    = cur_q.w;
   assign weight_height_o  = cur_q.wh;
   assign op_o             = cur_q.op;

`ifdef SCHED_PERF_CNT_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [15:0] perf_layers_q, perf_layers_d;

   // Busy-cycle count saturates; layer count wraps.
   always_comb begin
      perf_busy_d   = perf_busy_q;
      if (busy_q && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
      perf_layers_d = perf_layers_q + {15'd0, layer_done_q};
   end

   // Performance counters clear on reset only.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_busy_q   <= '0;
         perf_layers_q <= '0;
      end else begin
         perf_busy_q   <= perf_busy_d;
         perf_layers_q <= perf_layers_d;
      end
   end

   assign perf_busy_cycles = perf_busy_q;
   assign perf_layers      = perf_layers_q;
`else
   assign perf_busy_cycles = '0;
   assign perf_layers      = '0;
`endif

endmodule

// File: tb/tb_systolic_layer_scheduler.sv
// Bench for systolic_layer_scheduler: loader/data-buffer responders plus a timeline model of each layer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_systolic_layer_scheduler;
   localparam int HEIGHT = 8;
   localparam int WIDTH  = 8;
   localparam int DRAIN  = HEIGHT + WIDTH;
   localparam int TMO    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        desc_valid, desc_ready, desc_op;
   logic [3:0]  desc_ifmap_height, desc_ifmap_width, desc_weight_height;
   logic        wload_req, wload_done, ifload_req, ifload_done;
   logic        layer_info_valid, send_sd_en, op_o, sd_ov, layer_done, busy;
   logic [3:0]  ifmap_height_o, ifmap_width_o, weight_height_o;
   logic        err_desc, err_timeout, err_clr;
   logic [31:0] perf_busy_cycles;
   logic [15:0] perf_layers;

   systolic_layer_scheduler dut (
      .clk(clk), .rst(rst),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_ifmap_height(desc_ifmap_height), .desc_ifmap_width(desc_ifmap_width),
      .desc_weight_height(desc_weight_height), .desc_op(desc_op),
      .wload_req(wload_req), .wload_done(wload_done),
      .ifload_req(ifload_req), .ifload_done(ifload_done),
      .layer_info_valid(layer_info_valid), .send_sd_en(send_sd_en),
      .ifmap_height_o(ifmap_height_o), .ifmap_width_o(ifmap_width_o),
      .weight_height_o(weight_height_o), .op_o(op_o),
      .sd_ov(sd_ov), .layer_done(layer_done), .busy(busy),
      .err_desc(err_desc), .err_timeout(err_timeout), .err_clr(err_clr),
      .perf_busy_cycles(perf_busy_cycles), .perf_layers(perf_layers)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int ld_delay = 2;
   bit ov_kill = 1'b0;
   bit noise = 1'b0;
   int next_pop = 0;
   bit exp_err = 1'b0;
   int busy_cnt = 0;
   int exp_start[$], exp_done[$], act_start[$], act_done[$];
   logic [12:0] exp_par[$], act_par[$];
   bit act_sen[$];
   int wcnt = 0, icnt = 0, ov_left = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Data-buffer rule: sd_ov high for (w+wh-1) cycles per pass; CONV makes h-wh+1 passes, MUL one.
   function automatic int ov_len(input int h, input int w, input int wh, input int op);
      return (op != 0) ? (w + wh - 1) : (h - wh + 1) * (w + wh - 1);
   endfunction

   // Timeline model: a descriptor accepted in cycle k pops once the scheduler is free, then
   // spends ld_delay+1 cycles in each load, one start cycle, the sd_ov burst, one low cycle,
   // the drain and the done cycle; the next pop is the cycle after done.
   function automatic void model_push(input int h, input int w, input int wh, input int op,
                                      input int k, input bit to);
      int p, s, l;
      p = (k + 1 > next_pop) ? k + 1 : next_pop;
      if (!(h >= 1 && h <= HEIGHT && w >= 1 && w <= WIDTH && wh >= 1 && wh <= HEIGHT &&
            (op == 1 || wh <= h))) begin
         next_pop = p + 1;
         exp_err  = 1'b1;
         return;
      end
      s = p + 1 + 2 * (ld_delay + 1);
      exp_start.push_back(s);
      exp_par.push_back(13'((h << 9) | (w << 5) | (wh << 1) | op));
      if (to) begin
         next_pop = s + TMO;
      end else begin
         l = s + ov_len(h, w, wh, op) + DRAIN + 2;
         exp_done.push_back(l);
         next_pop = l + 1;
      end
   endfunction

   // Loader and data-buffer responders.
   initial begin
      wload_done = 1'b0; ifload_done = 1'b0; sd_ov = 1'b0;
      forever begin
         @(negedge clk);
         wload_done = 1'b0; ifload_done = 1'b0;
         if (rst) begin
            wcnt = 0; icnt = 0; ov_left = 0; sd_ov = 1'b0;
         end else begin
            if (wload_req) begin
               if (wcnt >= ld_delay) begin wload_done = 1'b1; wcnt = 0; end else wcnt++;
            end else wcnt = 0;
            if (ifload_req) begin
               if (icnt >= ld_delay) begin ifload_done = 1'b1; icnt = 0; end else icnt++;
            end else icnt = 0;
            if (noise && (wload_req || sd_ov)) ifload_done = 1'b1;
            if (noise && (ifload_req || sd_ov)) wload_done = 1'b1;
            if (ov_left > 0) begin sd_ov = 1'b1; ov_left--; end else sd_ov = 1'b0;
            if (layer_info_valid && !ov_kill)
               ov_left = ov_len(int'(ifmap_height_o), int'(ifmap_width_o),
                                int'(weight_height_o), int'(op_o));
         end
      end
   end

   // Event recorder.
   always @(negedge clk) begin
      if (rst) busy_cnt = 0;
      else if (busy) busy_cnt++;
      if (layer_info_valid) begin
         act_start.push_back(cyc);
         act_par.push_back({ifmap_height_o, ifmap_width_o, weight_height_o, op_o});
         act_sen.push_back(send_sd_en);
      end
      if (layer_done) act_done.push_back(cyc);
   end

   task automatic send(input logic [3:0] h, input logic [3:0] w, input logic [3:0] wh,
                       input logic op, input bit to);
      int n = 0;
      desc_valid = 1'b1; desc_ifmap_height = h; desc_ifmap_width = w;
      desc_weight_height = wh; desc_op = op;
      while (desc_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      chk("push_ready", desc_ready, 1);
      model_push(int'(h), int'(w), int'(wh), int'(op), cyc, to);
      @(negedge clk);
      desc_valid = 1'b0;
   endtask

   task automatic gen(output logic [3:0] h, output logic [3:0] w, output logic [3:0] wh,
                      output logic op);
      h  = 4'($urandom_range(1, HEIGHT));
      w  = 4'($urandom_range(1, WIDTH));
      op = 1'($urandom_range(0, 1));
      wh = op ? 4'($urandom_range(1, HEIGHT)) : 4'($urandom_range(1, int'(h)));
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      chk("idle_bound", n < 3000, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_scenario(input string tag);
      chk({tag, "_nstart"}, act_start.size(), exp_start.size());
      chk({tag, "_ndone"}, act_done.size(), exp_done.size());
      foreach (exp_start[i]) begin
         if (i < act_start.size()) begin
            chk({tag, "_start_cyc"}, act_start[i], exp_start[i]);
            chk({tag, "_params"}, act_par[i], exp_par[i]);
            chk({tag, "_send_sd_en"}, act_sen[i], 1);
         end
      end
      foreach (exp_done[i]) begin
         if (i < act_done.size()) chk({tag, "_done_cyc"}, act_done[i], exp_done[i]);
      end
      exp_start.delete(); exp_done.delete(); exp_par.delete();
      act_start.delete(); act_done.delete(); act_par.delete(); act_sen.delete();
   endtask

   initial begin
      logic [3:0] h, w, wh;
      logic       op;
      int         s, n;
      desc_valid = 1'b0; desc_ifmap_height = '0; desc_ifmap_width = '0;
      desc_weight_height = '0; desc_op = 1'b0; err_clr = 1'b0;

      // Reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_desc_ready", desc_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_layer_done", layer_done, 0);
      chk("rst_send_sd_en", send_sd_en, 0);
      chk("rst_layer_info_valid", layer_info_valid, 0);
      chk("rst_err_desc", err_desc, 0);
      chk("rst_err_timeout", err_timeout, 0);
      chk("rst_wload_req", wload_req, 0);
      chk("rst_ifload_req", ifload_req, 0);
      chk("rst_params", {ifmap_height_o, ifmap_width_o, weight_height_o, op_o}, 0);
      rst = 1'b0;

      // Single CONV layer, loads answered 2 cycles after request
      ld_delay = 2;
      send(4'd6, 4'd4, 4'd3, 1'b0, 1'b0);
      wait_idle();
      check_scenario("conv1");

      // Second layer with random shape and minimum load latency, then perf counters
      ld_delay = 0;
      gen(h, w, wh, op);
      send(h, w, wh, op, 1'b0);
      wait_idle();
      check_scenario("rand1");
`ifdef SCHED_PERF_CNT_EN
      chk("perf_layers", perf_layers, 2);
      chk("perf_busy_cycles", perf_busy_cycles, busy_cnt);
`else
      chk("perf_layers_off", perf_layers, 0);
      chk("perf_busy_off", perf_busy_cycles, 0);
`endif

      // Illegal descriptors mixed with legal boundary ones; stray done pulses enabled
      noise = 1'b1;
      ld_delay = int'($urandom_range(0, 3));
      send(4'd3, 4'd2, 4'd5, 1'b0, 1'b0);
      send(4'd0, 4'd3, 4'd1, 1'b1, 1'b0);
      send(4'd4, 4'd9, 4'd2, 1'b1, 1'b0);
      send(4'd5, 4'd3, 4'd9, 1'b1, 1'b0);
      send(4'd2, 4'd3, 4'd5, 1'b1, 1'b0);
      send(4'd8, 4'd8, 4'd8, 1'b0, 1'b0);
      wait_idle();
      check_scenario("illegal");
      chk("err_desc_set", err_desc, exp_err);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_err = 1'b0;
      chk("err_desc_clr", err_desc, exp_err);

      // FIFO full: five back-to-back layers, a sixth offered while full
      ld_delay = int'($urandom_range(0, 3));
      for (int i = 0; i < 5; i++) begin
         gen(h, w, wh, op);
         send(h, w, wh, op, 1'b0);
      end
      gen(h, w, wh, op);
      desc_valid = 1'b1; desc_ifmap_height = h; desc_ifmap_width = w;
      desc_weight_height = wh; desc_op = op;
      for (int i = 0; i < 3; i++) begin
         chk("full_desc_ready", desc_ready, 0);
         @(negedge clk);
      end
      desc_valid = 1'b0;
      wait_idle();
      check_scenario("fifo_full");
      noise = 1'b0;

      // Start timeout: sd_ov never rises
      ov_kill = 1'b1;
      ld_delay = 1;
      gen(h, w, wh, op);
      send(h, w, wh, op, 1'b1);
      s = exp_start[$];
      n = 0;
      while (cyc < s + TMO - 1 && n < 500) begin @(negedge clk); n++; end
      chk("tmo_err_before", err_timeout, 0);
      @(negedge clk);
      chk("tmo_err_set", err_timeout, 1);
      chk("tmo_busy", busy, 0);
      wait_idle();
      ov_kill = 1'b0;
      check_scenario("timeout");
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_err_clr", err_timeout, 0);

      // Reset in the middle of a layer with a second descriptor queued
      ld_delay = 1;
      send(4'd8, 4'd8, 4'd1, 1'b0, 1'b0);
      send(4'd2, 4'd2, 4'd2, 1'b1, 1'b0);
      n = 0;
      while (act_start.size() == 0 && n < 200) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_desc_ready", desc_ready, 1);
      chk("mid_rst_params", {ifmap_height_o, ifmap_width_o, weight_height_o, op_o}, 0);
      repeat (150) @(negedge clk);
      chk("mid_rst_nstart", act_start.size(), 1);
      chk("mid_rst_ndone", act_done.size(), 0);
      exp_start.delete(); exp_done.delete(); exp_par.delete();
      act_start.delete(); act_done.delete(); act_par.delete(); act_sen.delete();
      next_pop = 0;

      // Recovery after reset
      gen(h, w, wh, op);
      send(h, w, wh, op, 1'b0);
      wait_idle();
      check_scenario("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
